// File: rtl/soc_system_vga_pkg.sv
// Shared timing defaults, RGB332 field layout and colour expansion for the VGA controller.
package soc_system_vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication keeps full-scale codes at 0xFF and zero at 0x00.
    function automatic rgb888_t rgb332_to_888(input logic [7:0] c);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        rgb888_t    px;
        r3   = c[R_MSB:R_LSB];
        g3   = c[G_MSB:G_LSB];
        b2   = c[B_MSB:B_LSB];
        px.r = {r3, r3, r3[2:1]};
        px.g = {g3, g3, g3[2:1]};
        px.b = {b2, b2, b2, b2};
        return px;
    endfunction

endpackage

// File: rtl/soc_system_vga_timing.sv
// Raster counters plus combinational active/sync/frame-boundary decodes.
module soc_system_vga_timing
    import soc_system_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          frame_first,
    output logic          frame_last
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_HI = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_HI = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic h_wrap;
    assign h_wrap = (h_cnt == H_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
            if (h_wrap)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end
    end

    assign active      = (h_cnt < H_ACT_HI) && (v_cnt < V_ACT_HI);
    assign hsync_act   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vsync_act   = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    assign frame_last  = h_wrap && (v_cnt == V_LAST);

endmodule

// File: rtl/soc_system_vga_ctrl.sv
// VGA output stage: per-frame RGB332 fill colour, registered sync/blank/colour.
// Optional test-pattern bars are enabled by defining VGA_TEST_PATTERN_EN.
module soc_system_vga_ctrl
    import soc_system_vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW       = $clog2(H_TOTAL),
    localparam int  VW       = $clog2(V_TOTAL)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_port,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_en,
`endif
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          hsync_act;
    logic          vsync_act;
    logic          frame_first;
    logic          frame_last;
    logic [7:0]    color_q;
    rgb888_t       pix;

    soc_system_vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hsync_act   (hsync_act),
        .vsync_act   (vsync_act),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    // Sampling only on the last pixel of a frame keeps software writes tear-free.
    always_ff @(posedge clk) begin
        if (!reset_n)
            color_q <= '0;
        else if (frame_last)
            color_q <= in_port;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;
    logic [2:0] k;

    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++)
            if (h_cnt >= HW'(i * BAR_W))
                bar = 3'(i);
    end

    // Index reversed so the leftmost bar is white, ending with black.
    assign k = ~bar;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pix = rgb332_to_888(color_q);
        if (test_en) begin
            pix.r = {8{k[1]}};
            pix.g = {8{k[2]}};
            pix.b = {8{k[0]}};
        end
    end
`else
    always_comb begin
        pix = rgb332_to_888(color_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= active ? pix.r : 8'h00;
            vga_g       <= active ? pix.g : 8'h00;
            vga_b       <= active ? pix.b : 8'h00;
            vga_hs      <= hsync_act ? HS_POL : ~HS_POL;
            vga_vs      <= vsync_act ? VS_POL : ~VS_POL;
            vga_blank_n <= active;
            frame_start <= frame_first;
        end
    end

endmodule
